// File: rtl/fft_ip_loader.sv
// fft_ip_loader: converts raw signed integer samples to saturated signed fixed
// point, buffers one frame of LENGTH samples, then replays it in natural or
// bit-reversed order with start/end-of-frame markers.
module fft_ip_loader #(
   parameter int LENGTH = 8,
   parameter int IN_W   = 32,
   parameter int OUT_W  = 32,
   parameter int FRAC_W = 16,
   parameter int BITREV = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_sof,
   output logic                    out_eof,
   input  logic                    sat_clr,
   output logic                    sat_flag
);

   localparam int AW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
   localparam int VW = IN_W + FRAC_W;
   // One guard bit above the wider of the scaled input and the output format
   // so the clamp comparisons never wrap.
   localparam int CW = ((VW > OUT_W) ? VW : OUT_W) + 1;
   localparam logic signed [CW-1:0] MAXV = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [CW-1:0] MINV = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
   localparam logic [AW-1:0] LAST = AW'(LENGTH - 1);

   typedef enum logic {S_FILL, S_DRAIN} state_t;

   state_t                  state_q, state_d;
   logic [AW-1:0]           wr_cnt_q, wr_cnt_d;
   logic [AW-1:0]           rd_cnt_q, rd_cnt_d;
   logic                    sat_flag_q, sat_flag_d;
   logic signed [OUT_W-1:0] mem_q [LENGTH];

   logic                    in_accept;
   logic                    out_fire;
   logic signed [CW-1:0]    in_scaled;
   logic [AW-1:0]           rd_addr;

   function automatic logic signed [CW-1:0] scale(input logic signed [IN_W-1:0] x);
      logic signed [CW-1:0] v;
      v = {{(CW-IN_W){x[IN_W-1]}}, x};
      return v <<< FRAC_W;
   endfunction

   function automatic logic sat_hit(input logic signed [CW-1:0] v);
      return (v > MAXV) || (v < MINV);
   endfunction

   function automatic logic signed [OUT_W-1:0] sat_fixed(input logic signed [CW-1:0] v);
      if (v > MAXV) return MAXV[OUT_W-1:0];
      else if (v < MINV) return MINV[OUT_W-1:0];
      else return v[OUT_W-1:0];
   endfunction

   function automatic logic [AW-1:0] rev_addr(input logic [AW-1:0] a);
      logic [AW-1:0] r;
      for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
      return r;
   endfunction

   // Handshake strobes decode from the state register only; rst_n masks them
   // so nothing is offered or accepted while reset is held.
   assign in_ready  = rst_n && (state_q == S_FILL);
   assign out_valid = rst_n && (state_q == S_DRAIN);
   assign in_accept = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   assign in_scaled = scale(in_data);
   assign rd_addr   = (BITREV != 0) ? rev_addr(rd_cnt_q) : rd_cnt_q;
   assign out_data  = out_valid ? mem_q[rd_addr] : '0;
   assign out_sof   = out_valid && (rd_cnt_q == '0);
   assign out_eof   = out_valid && (rd_cnt_q == LAST);
   assign sat_flag  = sat_flag_q;

   // Control state: FSM, frame counters and sticky saturation flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_FILL;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         sat_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         sat_flag_q <= sat_flag_d;
      end
   end

   // Next-state: fill until LENGTH accepts, drain until LENGTH handshakes.
   always_comb begin
      state_d    = state_q;
      wr_cnt_d   = wr_cnt_q;
      rd_cnt_d   = rd_cnt_q;
      sat_flag_d = sat_flag_q;
      if (in_accept) begin
         if (wr_cnt_q == LAST) begin
            wr_cnt_d = '0;
            state_d  = S_DRAIN;
         end else begin
            wr_cnt_d = wr_cnt_q + AW'(1);
         end
      end
      if (out_fire) begin
         if (rd_cnt_q == LAST) begin
            rd_cnt_d = '0;
            state_d  = S_FILL;
         end else begin
            rd_cnt_d = rd_cnt_q + AW'(1);
         end
      end
      // A saturating accept outranks a simultaneous clear.
      if (in_accept && sat_hit(in_scaled)) sat_flag_d = 1'b1;
      else if (sat_clr)                    sat_flag_d = 1'b0;
   end

   // Frame buffer holds already-converted samples; contents need no reset.
   always_ff @(posedge clk) begin
      if (in_accept) mem_q[wr_cnt_q] <= sat_fixed(in_scaled);
   end

endmodule

// File: tb/tb_fft_ip_loader.sv
// Directed bench for fft_ip_loader: natural and bit-reversed replay,
// saturation, backpressure, input gaps and mid-frame reset.
module tb_fft_ip_loader;

   logic               clk;
   logic               rst_n;
   logic               in_valid, in_ready, out_valid, out_ready;
   logic signed [31:0] in_data, out_data;
   logic               out_sof, out_eof, sat_clr, sat_flag;

   logic               in_valid_b, in_ready_b, out_valid_b, out_ready_b;
   logic signed [31:0] in_data_b, out_data_b;
   logic               out_sof_b, out_eof_b, sat_clr_b, sat_flag_b;

   int n_cmp;
   int n_bad;

   int                 stim [8];
   logic signed [31:0] got_data [8];
   logic               got_sof [8];
   logic               got_eof [8];
   int                 got_n;
   int                 drain_cyc;
   bit                 ir_seen;

   fft_ip_loader dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sof(out_sof), .out_eof(out_eof),
      .sat_clr(sat_clr), .sat_flag(sat_flag)
   );

   fft_ip_loader #(.BITREV(1)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
      .out_sof(out_sof_b), .out_eof(out_eof_b),
      .sat_clr(sat_clr_b), .sat_flag(sat_flag_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents stim[first .. first+n-1], optionally with idle gaps between samples.
   task automatic fill(input int first, input int n, input bit gaps);
      for (int i = first; i < first + n; i++) begin
         if (gaps && (i % 2 == 1)) begin
            in_valid = 1'b0;
            in_data  = 32'sh0BAD0BAD;
            repeat (1 + $urandom_range(0, 2)) tick();
         end
         in_valid = 1'b1;
         in_data  = stim[i];
         tick();
      end
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   // Records up to n output samples with out_ready held high, bounded in time.
   task automatic collect(input int n);
      int cyc;
      got_n     = 0;
      cyc       = 0;
      ir_seen   = 1'b0;
      out_ready = 1'b1;
      while (got_n < n && cyc < 64) begin
         if (in_ready) ir_seen = 1'b1;
         if (out_valid) begin
            got_data[got_n] = out_data;
            got_sof[got_n]  = out_sof;
            got_eof[got_n]  = out_eof;
            got_n++;
         end
         tick();
         cyc++;
      end
      drain_cyc = cyc;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 0; in_data = '0; out_ready = 0; sat_clr = 0;
      in_valid_b = 0; in_data_b = '0; out_ready_b = 0; sat_clr_b = 0;
      tick(); tick();
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      n_cmp++; if ({out_sof, out_eof, sat_flag} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b want 000", {out_sof, out_eof, sat_flag}); end
      n_cmp++; if (out_data !== 32'sh0) begin n_bad++; $display("FAIL rst_out_data: got %h want 0", out_data); end
      rst_n = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'sh0) begin n_bad++; $display("FAIL rst_after: valid %b data %h want 0/0", out_valid, out_data); end
   endtask

   task automatic test_natural();
      for (int i = 0; i < 8; i++) stim[i] = i + 1;
      fill(0, 7, 1'b0);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL nat_early: out_valid %b want 0", out_valid); end
      fill(7, 1, 1'b0);
      n_cmp++; if (out_valid !== 1'b1 || out_sof !== 1'b1) begin n_bad++; $display("FAIL nat_latency: valid %b sof %b want 1 1", out_valid, out_sof); end
      collect(8);
      n_cmp++; if (got_n !== 8) begin n_bad++; $display("FAIL nat_count: got %0d want 8", got_n); end
      for (int i = 0; i < got_n; i++) begin
         n_cmp++;
         if (got_data[i] !== 32'((i + 1) << 16) || got_sof[i] !== (i == 0) || got_eof[i] !== (i == 7)) begin
            n_bad++;
            $display("FAIL nat_out[%0d]: got %h sof %b eof %b want %h %b %b", i, got_data[i], got_sof[i], got_eof[i], 32'((i + 1) << 16), (i == 0), (i == 7));
         end
      end
      n_cmp++; if (drain_cyc !== 8 || ir_seen !== 1'b0) begin n_bad++; $display("FAIL nat_ready_low: cycles %0d ready_seen %b want 8 0", drain_cyc, ir_seen); end
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL nat_return: ready %b valid %b want 1 0", in_ready, out_valid); end
   endtask

   task automatic test_bitrev();
      int exp_idx [8];
      int cnt;
      int cyc;
      exp_idx = '{0, 4, 2, 6, 1, 5, 3, 7};
      for (int i = 0; i < 8; i++) begin
         in_valid_b = 1'b1;
         in_data_b  = i;
         tick();
      end
      in_valid_b  = 1'b0;
      out_ready_b = 1'b1;
      cnt = 0;
      cyc = 0;
      while (cnt < 8 && cyc < 64) begin
         if (out_valid_b) begin
            n_cmp++;
            if (out_data_b !== 32'(exp_idx[cnt] << 16) || out_sof_b !== (cnt == 0) || out_eof_b !== (cnt == 7)) begin
               n_bad++;
               $display("FAIL br_out[%0d]: got %h sof %b eof %b want %h %b %b", cnt, out_data_b, out_sof_b, out_eof_b, 32'(exp_idx[cnt] << 16), (cnt == 0), (cnt == 7));
            end
            cnt++;
         end
         tick();
         cyc++;
      end
      n_cmp++; if (cnt !== 8) begin n_bad++; $display("FAIL br_count: got %0d want 8", cnt); end
      n_cmp++; if (in_ready_b !== 1'b1) begin n_bad++; $display("FAIL br_return: ready %b want 1", in_ready_b); end
      out_ready_b = 1'b0;
   endtask

   task automatic test_saturation();
      logic signed [31:0] exp_sat [8];
      exp_sat = '{32'hFFFF0000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF,
                  32'h80000000, 32'h7FFF0000, 32'h00000000, 32'h00050000};
      in_valid = 1'b1; in_data = -1; tick();
      n_cmp++; if (sat_flag !== 1'b0) begin n_bad++; $display("FAIL sat_neg1: flag %b want 0", sat_flag); end
      in_data = 32768; tick();
      n_cmp++; if (sat_flag !== 1'b1) begin n_bad++; $display("FAIL sat_pos: flag %b want 1", sat_flag); end
      in_valid = 1'b0; sat_clr = 1'b1; tick(); sat_clr = 1'b0;
      n_cmp++; if (sat_flag !== 1'b0) begin n_bad++; $display("FAIL sat_clear: flag %b want 0", sat_flag); end
      in_valid = 1'b1; in_data = -32769; tick();
      n_cmp++; if (sat_flag !== 1'b1) begin n_bad++; $display("FAIL sat_neg: flag %b want 1", sat_flag); end
      sat_clr = 1'b1; in_data = 40000; tick();
      n_cmp++; if (sat_flag !== 1'b1) begin n_bad++; $display("FAIL sat_set_wins: flag %b want 1", sat_flag); end
      in_valid = 1'b0; tick(); sat_clr = 1'b0;
      n_cmp++; if (sat_flag !== 1'b0) begin n_bad++; $display("FAIL sat_clear2: flag %b want 0", sat_flag); end
      in_valid = 1'b1;
      in_data = -32768; tick();
      in_data = 32767;  tick();
      in_data = 0;      tick();
      in_data = 5;      tick();
      in_valid = 1'b0;
      n_cmp++; if (sat_flag !== 1'b0) begin n_bad++; $display("FAIL sat_edges: flag %b want 0", sat_flag); end
      collect(8);
      n_cmp++; if (got_n !== 8) begin n_bad++; $display("FAIL sat_count: got %0d want 8", got_n); end
      for (int i = 0; i < got_n; i++) begin
         n_cmp++;
         if (got_data[i] !== exp_sat[i]) begin n_bad++; $display("FAIL sat_out[%0d]: got %h want %h", i, got_data[i], exp_sat[i]); end
      end
   endtask

   task automatic test_backpressure();
      int cnt;
      int cyc;
      for (int i = 0; i < 8; i++) stim[i] = 10 + i;
      fill(0, 8, 1'b0);
      cnt = 0;
      cyc = 0;
      while (cnt < 8 && cyc < 100) begin
         out_ready = (cyc % 3 == 0);
         #1;
         if (out_valid) begin
            n_cmp++;
            if (out_data !== 32'((10 + cnt) << 16) || out_sof !== (cnt == 0) || out_eof !== (cnt == 7) || in_ready !== 1'b0) begin
               n_bad++;
               $display("FAIL bp_out[%0d] cyc %0d: got %h sof %b eof %b ready %b want %h %b %b 0", cnt, cyc, out_data, out_sof, out_eof, in_ready, 32'((10 + cnt) << 16), (cnt == 0), (cnt == 7));
            end
            if (out_ready) cnt++;
         end
         tick();
         cyc++;
      end
      n_cmp++; if (cnt !== 8) begin n_bad++; $display("FAIL bp_count: got %0d want 8", cnt); end
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_return: ready %b valid %b want 1 0", in_ready, out_valid); end
      out_ready = 1'b1;
   endtask

   task automatic test_gaps();
      for (int i = 0; i < 8; i++) stim[i] = 20 + i;
      fill(0, 8, 1'b1);
      n_cmp++; if (out_valid !== 1'b1 || out_sof !== 1'b1) begin n_bad++; $display("FAIL gap_latency: valid %b sof %b want 1 1", out_valid, out_sof); end
      collect(8);
      n_cmp++; if (got_n !== 8) begin n_bad++; $display("FAIL gap_count: got %0d want 8", got_n); end
      for (int i = 0; i < got_n; i++) begin
         n_cmp++;
         if (got_data[i] !== 32'((20 + i) << 16)) begin n_bad++; $display("FAIL gap_out[%0d]: got %h want %h", i, got_data[i], 32'((20 + i) << 16)); end
      end
   endtask

   task automatic test_reset_mid_fill();
      for (int i = 0; i < 5; i++) stim[i] = 100 + i;
      fill(0, 5, 1'b0);
      rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL rmf_state: ready %b valid %b want 1 0", in_ready, out_valid); end
      for (int i = 0; i < 8; i++) stim[i] = 30 + i;
      fill(0, 7, 1'b0);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmf_early: valid %b want 0", out_valid); end
      fill(7, 1, 1'b0);
      collect(8);
      n_cmp++; if (got_n !== 8) begin n_bad++; $display("FAIL rmf_count: got %0d want 8", got_n); end
      for (int i = 0; i < got_n; i++) begin
         n_cmp++;
         if (got_data[i] !== 32'((30 + i) << 16) || got_sof[i] !== (i == 0)) begin
            n_bad++;
            $display("FAIL rmf_out[%0d]: got %h sof %b want %h %b", i, got_data[i], got_sof[i], 32'((30 + i) << 16), (i == 0));
         end
      end
   endtask

   task automatic test_reset_mid_drain();
      stim[0] = 40000;
      for (int i = 1; i < 8; i++) stim[i] = 40 + i;
      fill(0, 8, 1'b0);
      n_cmp++; if (sat_flag !== 1'b1) begin n_bad++; $display("FAIL rmd_sat: flag %b want 1", sat_flag); end
      collect(3);
      n_cmp++; if (got_n !== 3) begin n_bad++; $display("FAIL rmd_partial: got %0d want 3", got_n); end
      rst_n = 1'b0; tick();
      n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'sh0 || in_ready !== 1'b0 || sat_flag !== 1'b0) begin
         n_bad++;
         $display("FAIL rmd_reset: valid %b data %h ready %b sat %b want 0 0 0 0", out_valid, out_data, in_ready, sat_flag);
      end
      rst_n = 1'b1; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rmd_release: ready %b want 1", in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmd_idle: valid %b want 0", out_valid); end
      for (int i = 0; i < 8; i++) stim[i] = 50 + i;
      fill(0, 8, 1'b0);
      collect(8);
      n_cmp++; if (got_n !== 8) begin n_bad++; $display("FAIL rmd_count: got %0d want 8", got_n); end
      for (int i = 0; i < got_n; i++) begin
         n_cmp++;
         if (got_data[i] !== 32'((50 + i) << 16) || got_sof[i] !== (i == 0) || got_eof[i] !== (i == 7)) begin
            n_bad++;
            $display("FAIL rmd_out[%0d]: got %h sof %b eof %b want %h %b %b", i, got_data[i], got_sof[i], got_eof[i], 32'((50 + i) << 16), (i == 0), (i == 7));
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_natural();
      test_bitrev();
      test_saturation();
      test_backpressure();
      test_gaps();
      test_reset_mid_fill();
      test_reset_mid_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fft_ip_loader.md
# fft_ip_loader

Streaming front-end for the R2SDF FFT that takes raw signed integer samples over a valid/ready handshake, converts each to signed fixed point (shift left by FRAC_W, with saturation), and buffers one frame of LENGTH samples. It replays the frame to the FFT datapath in natural or bit-reversed order, with start-of-frame and end-of-frame markers. It replaces the static, initial-block array conversion with a synthesizable, parametrised, back-pressured block.

## Interface
- LENGTH, 8: samples per frame; power of two, >= 2.
- IN_W, 32: raw input sample width, signed.
- OUT_W, 32: converted fixed-point width, signed; OUT_W > FRAC_W.
- FRAC_W, 16: fraction bits of the output format.
- BITREV, 0: 0 = drain in natural order; 1 = drain in bit-reversed index order.
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  raw sample present.
- in_ready  out  1  loader accepts a sample this cycle.
- in_data  in  IN_W  raw signed integer sample.
- out_valid  out  1  converted sample present.
- out_ready  in  1  downstream accepts the sample.
- out_data  out  OUT_W  converted signed fixed-point sample.
- out_sof  out  1  first sample of the frame; qualified by out_valid.
- out_eof  out  1  last sample of the frame; qualified by out_valid.
- sat_clr  in  1  clears sat_flag.
- sat_flag  out  1  sticky flag: a sample saturated since the last clear or reset.

## Operation
- Two states:
  - FILL: in_ready = 1; each accepted sample (in_valid && in_ready) is converted and written to buf[wr_cnt], then wr_cnt increments.
  - DRAIN: in_ready = 0; the block presents buf[addr(rd_cnt)] on out_data.
- FILL -> DRAIN on the accept with wr_cnt == LENGTH-1; wr_cnt wraps to 0.
- DRAIN -> FILL on the handshake (out_valid && out_ready) with rd_cnt == LENGTH-1; rd_cnt wraps to 0.
- addr(rd_cnt) = rd_cnt when BITREV = 0. When BITREV = 1, it is rd_cnt with its log2(LENGTH) bits reversed.
- Conversion computes v = in_data * 2^FRAC_W at IN_W+FRAC_W bits, then clamps:
  - v > 2^(OUT_W-1)-1 -> 2^(OUT_W-1)-1.
  - v < -2^(OUT_W-1) -> -2^(OUT_W-1).
  - Otherwise, the low OUT_W bits of v.
- The conversion is applied on write, so the buffer holds converted values.
- sat_flag is set on the accept of any clamped sample and cleared by sat_clr. If both occur in the same cycle, set wins.
- out_sof = out_valid && rd_cnt == 0; out_eof = out_valid && rd_cnt == LENGTH-1.
- out_data = 0 whenever out_valid = 0.
- Reset, including mid-frame, returns to FILL with wr_cnt = rd_cnt = 0 and sat_flag = 0. Any partial frame is discarded and never emitted. Buffer contents are don't-care.

## Timing
- Outputs while rst_n = 0 and in the first cycle after: in_ready = 0 during reset, 1 from the first cycle with rst_n = 1. out_valid, out_sof, out_eof and sat_flag are 0, and out_data is 0.
- in_ready and out_valid decode directly from the state register, with no combinational path from in_valid or out_ready.
- Latency: the first output (out_valid = 1, sof) appears the cycle after the LENGTH-th input accept.
- in_ready returns to 1 the cycle after the eof handshake.
- Minimum period is 2*LENGTH cycles per frame; there is no fill/drain overlap.
- With out_valid = 1 and out_ready = 0, out_data, out_sof, out_eof and rd_cnt hold stable.
- With in_valid = 0 in FILL, nothing is written and wr_cnt holds.

## Test plan
- Natural order (defaults): in_data 1..8 back-to-back with out_ready = 1.
  - out_data = 0x00010000 .. 0x00080000.
  - out_sof on the 1st output, out_eof on the 8th.
  - First output appears 1 cycle after the 8th accept; in_ready = 0 for exactly 8 cycles.
- Bit-reversed (BITREV = 1): inputs 0..7.
  - Outputs in index order 0,4,2,6,1,5,3,7 (0x00000000, 0x00040000, 0x00020000, …).
- Saturation and sign handling:
  - Input -1 -> 0xFFFF0000, sat_flag stays 0.
  - Input 32768 -> 0x7FFFFFFF, sat_flag = 1.
  - Input -32769 -> 0x80000000.
  - sat_clr together with a saturating accept leaves sat_flag = 1; sat_clr alone clears it next cycle.
- Backpressure: toggle out_ready 1,0,0,1,…
  - Every output value and sof/eof is held while out_ready = 0.
  - All 8 samples are delivered once, in order; in_ready stays 0 until after eof.
- Input gaps: in_valid deasserted randomly in FILL.
  - Only valid samples are counted; the frame still contains exactly 8 samples in order.
- Reset mid-operation:
  - Reset after 5 accepts, then 8 fresh samples -> only the 8 fresh samples are emitted.
  - Reset during DRAIN after 3 outputs -> out_valid = 0 next cycle, in_ready = 1 after reset releases.
